// File: rtl/vliw_id_stage_param.sv
// ============================================================================
// Module   : vliw_id_stage_param
// Purpose  : Dual-slot (ALU + MEM) VLIW decode stage with 2W/4R bypassed
//            register file, load-use bubble insertion and ID/EX register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vliw_id_stage_param #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 3,
    parameter int LU_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       p1_aluInstr,
    input  logic [15:0]       p1_memInstr,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              p4_alu_regWrite,
    input  logic              p4_mem_regWrite,
    input  logic [REG_AW-1:0] p4_alu_wa,
    input  logic [REG_AW-1:0] p4_mem_wa,
    input  logic [DATA_W-1:0] p4_alu_writeData,
    input  logic [DATA_W-1:0] p4_mem_writeData,
    output logic              p2_valid,
    output logic [REG_AW-1:0] p2_alu_rm,
    output logic [REG_AW-1:0] p2_alu_rn,
    output logic [REG_AW-1:0] p2_alu_rd,
    output logic [REG_AW-1:0] p2_mem_rn,
    output logic [REG_AW-1:0] p2_mem_rd,
    output logic [DATA_W-1:0] p2_alu_reg_rm,
    output logic [DATA_W-1:0] p2_alu_reg_rn,
    output logic [DATA_W-1:0] p2_mem_reg_rn,
    output logic [DATA_W-1:0] p2_mem_reg_rd,
    output logic [DATA_W-1:0] p2_alu_imm,
    output logic [DATA_W-1:0] p2_mem_offset,
    output logic [DATA_W-1:0] p2_branchOffset,
    output logic [DATA_W-1:0] p2_jumpOffset,
    output logic              p2_memRead,
    output logic              p2_memWrite,
    output logic              p2_alu_regWrite,
    output logic              p2_mem_regWrite,
    output logic              p2_aluOp,
    output logic              p2_aluSrcB,
    output logic              p2_isBranch,
    output logic              p2_isJump,
    output logic              p2_alu_undef,
    output logic              p2_mem_undef
);

    localparam int         c_NREGS  = 1 << REG_AW;
    localparam logic [2:0] c_LU_CNT = 3'(LU_BUBBLES - 1);

    typedef enum logic [0:0] {S_RUN = 1'b0, S_BUBBLE = 1'b1} state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] alu_rm, alu_rn, alu_rd, mem_rn, mem_rd;
        logic [DATA_W-1:0] alu_reg_rm, alu_reg_rn, mem_reg_rn, mem_reg_rd;
        logic [DATA_W-1:0] alu_imm, mem_offset, branchOffset, jumpOffset;
        logic              memRead, memWrite, alu_regWrite, mem_regWrite;
        logic              aluOp, aluSrcB, isBranch, isJump;
        logic              alu_undef, mem_undef;
    } p2_t;

    logic [DATA_W-1:0] r_rf [0:c_NREGS-1];
    p2_t               r_p2, w_p2_nxt, w_dec;
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              w_hazard, w_in_ready;
    logic              w_use_alu_rm, w_use_alu_rn, w_use_mem_rn, w_use_mem_rd;
    logic [DATA_W-1:0] w_br_sext, w_jmp_sext;

    // Bypassed read; the MEM write port wins when both target the same reg.
    function automatic logic [DATA_W-1:0] rf_read(input logic [REG_AW-1:0] a);
        if (p4_mem_regWrite && p4_mem_wa == a)
            return p4_mem_writeData;
        else if (p4_alu_regWrite && p4_alu_wa == a)
            return p4_alu_writeData;
        else
            return r_rf[a];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NREGS; i++) r_rf[i] <= '0;
        end else begin
            if (p4_alu_regWrite) r_rf[p4_alu_wa] <= p4_alu_writeData;
            if (p4_mem_regWrite) r_rf[p4_mem_wa] <= p4_mem_writeData;
        end
    end

    always_comb begin
        w_dec        = '0;
        w_use_alu_rm = 1'b0;
        w_use_alu_rn = 1'b0;
        w_use_mem_rn = 1'b0;
        w_use_mem_rd = 1'b0;
        w_dec.valid  = 1'b1;
        w_dec.alu_rm[2:0] = p1_aluInstr[15:13];
        w_dec.alu_rn[2:0] = p1_aluInstr[12:10];
        w_dec.alu_rd[2:0] = p1_aluInstr[9:7];
        w_dec.mem_rn[2:0] = p1_memInstr[10:8];
        w_dec.mem_rd[2:0] = p1_memInstr[7:5];
        w_dec.alu_reg_rm  = rf_read(w_dec.alu_rm);
        w_dec.alu_reg_rn  = rf_read(w_dec.alu_rn);
        w_dec.mem_reg_rn  = rf_read(w_dec.mem_rn);
        w_dec.mem_reg_rd  = rf_read(w_dec.mem_rd);
        w_dec.alu_imm     = {{(DATA_W-3){p1_aluInstr[12]}}, p1_aluInstr[12:10]};
        w_dec.mem_offset  = {{(DATA_W-5){p1_memInstr[15]}}, p1_memInstr[15:11]};
        w_br_sext         = {{(DATA_W-8){p1_memInstr[15]}}, p1_memInstr[15:8]};
        w_jmp_sext        = {{(DATA_W-11){p1_memInstr[15]}}, p1_memInstr[15:5]};
        w_dec.branchOffset = {w_br_sext[DATA_W-2:0], 1'b0};
        w_dec.jumpOffset   = {w_jmp_sext[DATA_W-2:0], 1'b0};

        case (p1_aluInstr[6:0])
            7'h00: ;
            7'h01: begin w_dec.alu_regWrite = 1'b1; w_use_alu_rm = 1'b1; w_use_alu_rn = 1'b1; end
            7'h02: begin w_dec.alu_regWrite = 1'b1; w_dec.aluOp = 1'b1;
                         w_use_alu_rm = 1'b1; w_use_alu_rn = 1'b1; end
            7'h03: begin w_dec.alu_regWrite = 1'b1; w_dec.aluSrcB = 1'b1; w_use_alu_rm = 1'b1; end
            default: w_dec.alu_undef = 1'b1;
        endcase

        case (p1_memInstr[4:0])
            5'h00: ;
            5'h01: begin w_dec.memRead = 1'b1; w_dec.mem_regWrite = 1'b1; w_use_mem_rn = 1'b1; end
            5'h02: begin w_dec.memWrite = 1'b1; w_use_mem_rn = 1'b1; w_use_mem_rd = 1'b1; end
            5'h03: begin w_dec.isBranch = 1'b1; w_use_mem_rn = 1'b1; end
            5'h04: w_dec.isJump = 1'b1;
            default: w_dec.mem_undef = 1'b1;
        endcase
    end

    assign w_hazard = r_p2.valid & r_p2.memRead & in_valid &
                      ((w_use_alu_rm & (w_dec.alu_rm == r_p2.mem_rd)) |
                       (w_use_alu_rn & (w_dec.alu_rn == r_p2.mem_rd)) |
                       (w_use_mem_rn & (w_dec.mem_rn == r_p2.mem_rd)) |
                       (w_use_mem_rd & (w_dec.mem_rd == r_p2.mem_rd)));

    assign w_in_ready = (r_state == S_RUN) & ex_ready & ~w_hazard & ~flush;
    assign in_ready   = w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_p2_nxt    = r_p2;
        if (flush) begin
            w_p2_nxt    = '0;
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
        end else if (ex_ready) begin
            w_p2_nxt = '0;
            if (r_state == S_RUN) begin
                if (w_hazard) begin
                    w_cnt_nxt   = c_LU_CNT;
                    w_state_nxt = (c_LU_CNT != 3'd0) ? S_BUBBLE : S_RUN;
                end else if (in_valid) begin
                    w_p2_nxt = w_dec;
                end
            end else if (r_cnt <= 3'd1) begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_RUN;
            end else begin
                w_cnt_nxt = r_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_p2    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p2    <= w_p2_nxt;
        end
    end

    assign p2_valid        = r_p2.valid;
    assign p2_alu_rm       = r_p2.alu_rm;
    assign p2_alu_rn       = r_p2.alu_rn;
    assign p2_alu_rd       = r_p2.alu_rd;
    assign p2_mem_rn       = r_p2.mem_rn;
    assign p2_mem_rd       = r_p2.mem_rd;
    assign p2_alu_reg_rm   = r_p2.alu_reg_rm;
    assign p2_alu_reg_rn   = r_p2.alu_reg_rn;
    assign p2_mem_reg_rn   = r_p2.mem_reg_rn;
    assign p2_mem_reg_rd   = r_p2.mem_reg_rd;
    assign p2_alu_imm      = r_p2.alu_imm;
    assign p2_mem_offset   = r_p2.mem_offset;
    assign p2_branchOffset = r_p2.branchOffset;
    assign p2_jumpOffset   = r_p2.jumpOffset;
    assign p2_memRead      = r_p2.memRead;
    assign p2_memWrite     = r_p2.memWrite;
    assign p2_alu_regWrite = r_p2.alu_regWrite;
    assign p2_mem_regWrite = r_p2.mem_regWrite;
    assign p2_aluOp        = r_p2.aluOp;
    assign p2_aluSrcB      = r_p2.aluSrcB;
    assign p2_isBranch     = r_p2.isBranch;
    assign p2_isJump       = r_p2.isJump;
    assign p2_alu_undef    = r_p2.alu_undef;
    assign p2_mem_undef    = r_p2.mem_undef;

endmodule

`default_nettype wire

// File: tb/tb_vliw_id_stage_param.sv
// ============================================================================
// Module   : tb_vliw_id_stage_param
// Purpose  : Directed, table-driven self-checking bench for the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vliw_id_stage_param;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, ex_ready, flush;
    logic [15:0] p1_aluInstr, p1_memInstr;
    logic        p4_alu_regWrite, p4_mem_regWrite;
    logic [2:0]  p4_alu_wa, p4_mem_wa;
    logic [31:0] p4_alu_writeData, p4_mem_writeData;
    logic        p2_valid;
    logic [2:0]  p2_alu_rm, p2_alu_rn, p2_alu_rd, p2_mem_rn, p2_mem_rd;
    logic [31:0] p2_alu_reg_rm, p2_alu_reg_rn, p2_mem_reg_rn, p2_mem_reg_rd;
    logic [31:0] p2_alu_imm, p2_mem_offset, p2_branchOffset, p2_jumpOffset;
    logic        p2_memRead, p2_memWrite, p2_alu_regWrite, p2_mem_regWrite;
    logic        p2_aluOp, p2_aluSrcB, p2_isBranch, p2_isJump, p2_alu_undef, p2_mem_undef;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vliw_id_stage_param #(.DATA_W(32), .REG_AW(3), .LU_BUBBLES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .p1_aluInstr(p1_aluInstr), .p1_memInstr(p1_memInstr),
        .ex_ready(ex_ready), .flush(flush),
        .p4_alu_regWrite(p4_alu_regWrite), .p4_mem_regWrite(p4_mem_regWrite),
        .p4_alu_wa(p4_alu_wa), .p4_mem_wa(p4_mem_wa),
        .p4_alu_writeData(p4_alu_writeData), .p4_mem_writeData(p4_mem_writeData),
        .p2_valid(p2_valid),
        .p2_alu_rm(p2_alu_rm), .p2_alu_rn(p2_alu_rn), .p2_alu_rd(p2_alu_rd),
        .p2_mem_rn(p2_mem_rn), .p2_mem_rd(p2_mem_rd),
        .p2_alu_reg_rm(p2_alu_reg_rm), .p2_alu_reg_rn(p2_alu_reg_rn),
        .p2_mem_reg_rn(p2_mem_reg_rn), .p2_mem_reg_rd(p2_mem_reg_rd),
        .p2_alu_imm(p2_alu_imm), .p2_mem_offset(p2_mem_offset),
        .p2_branchOffset(p2_branchOffset), .p2_jumpOffset(p2_jumpOffset),
        .p2_memRead(p2_memRead), .p2_memWrite(p2_memWrite),
        .p2_alu_regWrite(p2_alu_regWrite), .p2_mem_regWrite(p2_mem_regWrite),
        .p2_aluOp(p2_aluOp), .p2_aluSrcB(p2_aluSrcB),
        .p2_isBranch(p2_isBranch), .p2_isJump(p2_isJump),
        .p2_alu_undef(p2_alu_undef), .p2_mem_undef(p2_mem_undef)
    );

    // {memRead, memWrite, alu_regWrite, mem_regWrite, aluOp, aluSrcB,
    //  isBranch, isJump, alu_undef, mem_undef}
    logic [9:0] w_ctrl;
    assign w_ctrl = {p2_memRead, p2_memWrite, p2_alu_regWrite, p2_mem_regWrite,
                     p2_aluOp, p2_aluSrcB, p2_isBranch, p2_isJump,
                     p2_alu_undef, p2_mem_undef};

    typedef struct {
        string       name;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [9:0]  ctrl;
        logic [31:0] imm;
        logic [31:0] off;
        logic [31:0] br;
        logic [31:0] jmp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        p1_aluInstr = 16'h0000;
        p1_memInstr = 16'h0000;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] m);
        in_valid    = 1'b1;
        p1_aluInstr = a;
        p1_memInstr = m;
    endtask

    initial begin
        vecs[0] = '{"add",   {3'd1,3'd2,3'd3,7'h01}, 16'h0000, 10'b0010000000, 32'h2,        32'h0,        32'h0,        32'h0};
        vecs[1] = '{"sub",   {3'd0,3'd5,3'd1,7'h02}, 16'h0000, 10'b0010100000, 32'hFFFFFFFD, 32'h0,        32'h0,        32'h0};
        vecs[2] = '{"addi",  {3'd4,3'd3,3'd2,7'h03}, 16'h0000, 10'b0010010000, 32'h3,        32'h0,        32'h0,        32'h0};
        vecs[3] = '{"load",  16'h0000, 16'h8141,             10'b1001000000, 32'h0,        32'hFFFFFFF0, 32'hFFFFFF02, 32'hFFFFF814};
        vecs[4] = '{"store", 16'h0000, 16'h7B82,             10'b0100000000, 32'h0,        32'h0000000F, 32'h000000F6, 32'h000007B8};
        vecs[5] = '{"brz",   16'h0000, 16'hFF03,             10'b0000001000, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF0};
        vecs[6] = '{"jmp",   16'h0000, 16'h8004,             10'b0000000100, 32'h0,        32'hFFFFFFF0, 32'hFFFFFF00, 32'hFFFFF800};
        vecs[7] = '{"undef", 16'h007F, 16'h001F,             10'b0000000011, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[8] = '{"undef2",16'hE004, 16'h0005,             10'b0000000011, 32'h0,        32'h0,        32'h0,        32'h0};

        reset = 1'b1; ex_ready = 1'b1; flush = 1'b0; idle();
        p4_alu_regWrite = 1'b0; p4_mem_regWrite = 1'b0;
        p4_alu_wa = '0; p4_mem_wa = '0; p4_alu_writeData = '0; p4_mem_writeData = '0;
        step(); step();
        chk("rst_valid", {31'b0, p2_valid}, 32'h0);
        chk("rst_ctrl",  {22'b0, w_ctrl}, 32'h0);
        chk("rst_imm",   p2_alu_imm, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // table-driven decode vectors, idle cycle between each
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].alu, vecs[i].mem);
            step();
            chk({vecs[i].name, "_valid"}, {31'b0, p2_valid}, 32'h1);
            chk({vecs[i].name, "_ctrl"},  {22'b0, w_ctrl}, {22'b0, vecs[i].ctrl});
            chk({vecs[i].name, "_imm"},   p2_alu_imm, vecs[i].imm);
            chk({vecs[i].name, "_off"},   p2_mem_offset, vecs[i].off);
            chk({vecs[i].name, "_br"},    p2_branchOffset, vecs[i].br);
            chk({vecs[i].name, "_jmp"},   p2_jumpOffset, vecs[i].jmp);
            idle();
            step();
        end

        // write r2 then read it back through ADD rm=2
        p4_alu_regWrite = 1'b1; p4_alu_wa = 3'd2; p4_alu_writeData = 32'h1234;
        step();
        p4_alu_regWrite = 1'b0;
        issue({3'd2,3'd0,3'd1,7'h01}, 16'h0000);
        step();
        chk("wr_reg_rm",   p2_alu_reg_rm, 32'h1234);
        chk("wr_aluOp",    {31'b0, p2_aluOp}, 32'h0);
        chk("wr_regWrite", {31'b0, p2_alu_regWrite}, 32'h1);
        chk("wr_valid",    {31'b0, p2_valid}, 32'h1);

        // dual write to r5 with same-cycle STORE read of rd=5: MEM wins
        p4_alu_regWrite = 1'b1; p4_alu_wa = 3'd5; p4_alu_writeData = 32'hAAAA;
        p4_mem_regWrite = 1'b1; p4_mem_wa = 3'd5; p4_mem_writeData = 32'h5555;
        issue(16'h0000, 16'h00A2);
        step();
        p4_alu_regWrite = 1'b0; p4_mem_regWrite = 1'b0;
        chk("byp_mem_reg_rd", p2_mem_reg_rd, 32'h5555);
        chk("byp_memWrite",   {31'b0, p2_memWrite}, 32'h1);
        issue({3'd5,3'd2,3'd0,7'h01}, 16'h0000);
        step();
        chk("r5_stored", p2_alu_reg_rm, 32'h5555);
        chk("r2_stored", p2_alu_reg_rn, 32'h1234);
        idle();
        step();

        // load-use: LOAD rd=3, then ADD rm=3 -> two bubbles
        issue(16'h0000, 16'h0061);
        step();
        issue({3'd3,3'd0,3'd0,7'h01}, 16'h0000);
        #1;
        chk("lu_load_valid", {31'b0, p2_valid & p2_memRead}, 32'h1);
        chk("lu_rdy0", {31'b0, in_ready}, 32'h0);
        step();
        chk("lu_bub1_valid", {31'b0, p2_valid}, 32'h0);
        chk("lu_rdy1", {31'b0, in_ready}, 32'h0);
        step();
        chk("lu_bub2_valid", {31'b0, p2_valid}, 32'h0);
        chk("lu_rdy2", {31'b0, in_ready}, 32'h1);
        step();
        chk("lu_add_valid", {31'b0, p2_valid}, 32'h1);
        chk("lu_add_rm",    {29'b0, p2_alu_rm}, 32'h3);

        // stall holds p2 contents
        ex_ready = 1'b0;
        issue({3'd6,3'd0,3'd0,7'h02}, 16'h0000);
        step();
        chk("stall_valid", {31'b0, p2_valid}, 32'h1);
        chk("stall_rm",    {29'b0, p2_alu_rm}, 32'h3);
        chk("stall_aluOp", {31'b0, p2_aluOp}, 32'h0);
        ex_ready = 1'b1;
        idle();
        step();

        // enter BUBBLE, stall three cycles, then flush
        issue(16'h0000, 16'h0061);
        step();
        issue({3'd3,3'd0,3'd0,7'h01}, 16'h0000);
        step();
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bub_hold_rdy", {31'b0, in_ready}, 32'h0);
        end
        flush = 1'b1;
        #1;
        chk("flush_rdy", {31'b0, in_ready}, 32'h0);
        step();
        flush = 1'b0;
        chk("flush_valid", {31'b0, p2_valid}, 32'h0);
        ex_ready = 1'b1;
        #1;
        chk("post_flush_rdy", {31'b0, in_ready}, 32'h1);
        step();
        chk("post_flush_add", {31'b0, p2_valid}, 32'h1);

        // flush kills a live p2 bundle even with a bundle offered
        flush = 1'b1;
        issue({3'd1,3'd1,3'd1,7'h01}, 16'h0000);
        step();
        flush = 1'b0;
        chk("flush_kill", {31'b0, p2_valid}, 32'h0);
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vliw_id_stage_param.md
Name: vliw_id_stage_param

Overview:
Parametrised successor of the dual-slot (ALU + MEM) decode stage. It decodes one 16-bit bundle per cycle, reads an internal 2-write/4-read register file with same-cycle write-bypass, and sign-extends immediates and offsets to DATA_W. It detects load-use hazards and inserts a configurable number of bubbles, and drives a valid-tagged ID/EX pipeline register with stall (ex_ready) and flush. It sits between the fetch pipeline register and EX.

Parameters:
DATA_W, 32, datapath/register width (>=12)
REG_AW, 3, register address width; file holds 2**REG_AW regs (fields fixed 3 bits, zero-extended if REG_AW>3; REG_AW>=3)
LU_BUBBLES, 1, bubbles inserted on load-use hazard (1..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  p1 bundle valid
in_ready  out  1  stage accepts bundle this cycle
p1_aluInstr  in  16  ALU slot: rm[15:13] rn[12:10] rd[9:7] op[6:0]
p1_memInstr  in  16  MEM slot: rn[10:8] rd[7:5] op[4:0], off5[15:11], br8[15:8], jmp11[15:5]
ex_ready  in  1  EX accepts p2 contents
flush  in  1  kill p2 and pending bubbles
p4_alu_regWrite, p4_mem_regWrite  in  1 each  writeback enables
p4_alu_wa, p4_mem_wa  in  REG_AW each  writeback addresses
p4_alu_writeData, p4_mem_writeData  in  DATA_W each  writeback data
p2_valid  out  1  p2 holds live bundle
p2_alu_rm, p2_alu_rn, p2_alu_rd, p2_mem_rn, p2_mem_rd  out  REG_AW each
p2_alu_reg_rm, p2_alu_reg_rn, p2_mem_reg_rn, p2_mem_reg_rd  out  DATA_W each
p2_alu_imm, p2_mem_offset, p2_branchOffset, p2_jumpOffset  out  DATA_W each
p2_memRead, p2_memWrite, p2_alu_regWrite, p2_mem_regWrite, p2_aluOp, p2_aluSrcB, p2_isBranch, p2_isJump, p2_alu_undef, p2_mem_undef  out  1 each

Behaviour:
- Clock and reset: one clock clk; reset synchronous, active-high. On reset: all registers in the file =0, every p2_* output =0, FSM=RUN, bubble counter=0.
- ALU decode: 00 NOP; 01 ADD (regWrite); 02 SUB (regWrite, aluOp=1); 03 ADDI (regWrite, aluSrcB=1, imm=sext(rn field)). Any other op: alu_undef=1, all other ALU controls 0.
- MEM decode: 00 NOP; 01 LOAD (memRead, mem_regWrite, offset=sext(off5)); 02 STORE (memWrite, offset=sext(off5)); 03 BRZ (isBranch, branchOffset=sext(br8)<<1); 04 JMP (isJump, jumpOffset=sext(jmp11)<<1). Any other op: mem_undef=1, all other MEM controls 0.
- Offsets and immediates are always computed from their fields regardless of op. Shifts discard the MSB of the DATA_W-bit sext value.
- Register file: 4 combinational reads, 2 writes at clk.
  - Same-cycle bypass: a read whose address equals an active write address returns that write data.
  - Both ports writing the same address: MEM port wins, for both the stored value and the bypassed value.
- Source usage:
  - ALU rm: ADD, SUB, ADDI. ALU rn: ADD, SUB.
  - MEM rn: LOAD, STORE, BRZ. MEM rd: STORE.
- Load-use hazard: when p2_valid & p2_memRead & in_valid and p2_mem_rd equals any used source of the p1 bundle.
- FSM RUN:
  - in_ready = ex_ready & no hazard.
  - On hazard with ex_ready: p2 <= bubble (valid=0, controls 0), cnt <= LU_BUBBLES-1. Go to BUBBLE if cnt>0, else stay RUN; the bundle retries next cycle.
- FSM BUBBLE:
  - in_ready=0.
  - Each ex_ready cycle: p2 <= bubble and cnt decrements; at cnt==0 return to RUN.
- p2 load: when in_valid & in_ready, p2 <= decoded bundle with valid=1. Registers read in this cycle are latched, bypass included.
- Stall: ex_ready=0 holds all p2 outputs and the FSM state unchanged.
- Bubble insertion: when ex_ready=1 and no bundle is accepted, p2 <= bubble.
- Flush: takes priority over everything except reset.
  - p2 <= bubble; FSM -> RUN; cnt -> 0; in_ready=0 that cycle.
- Latency: 1 cycle, p1 to p2.

Test Plan:
- Reset, then write p4_alu (wa=2, data=0x1234). Next cycle issue ALU ADD rm=2 → p2_alu_reg_rm=0x1234, p2_aluOp=0, p2_alu_regWrite=1, p2_valid=1.
- Same-cycle writes p4_alu wa=5 data=0xAAAA and p4_mem wa=5 data=0x5555, with a MEM STORE reading rd=5 in that cycle → p2_mem_reg_rd=0x5555, and r5 reads 0x5555 later.
- LOAD rd=3 then ADD rm=3 (LU_BUBBLES=2) → in_ready low 2 cycles, p2_valid 0,0, then ADD latched with valid=1.
- MEM BRZ br8=0xFF, JMP jmp11=0x400 → p2_branchOffset=0xFFFFFFFE, p2_jumpOffset=0xFFFFF800 (DATA_W=32).
- ALU op=0x7F, MEM op=0x1F → p2_alu_undef=1, p2_mem_undef=1, all other controls 0.
- During BUBBLE state with ex_ready=0 hold for 3 cycles, assert flush → p2_valid=0, next cycle in_ready=1 and FSM in RUN.
